// File: rtl/id_ex_stage_if.sv
// Decode/hazard-unit to EX stage bundle: decode fields and hazard decisions in,
// EX-side register contents, stall hold and watchdog status out.
interface id_ex_stage_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
);
  logic              doStall;
  logic              doFwd;
  logic              flush;
  logic              inValid;
  logic [2:0]        inWreg;
  logic              inEnFile;
  logic              inUseAlu;
  logic [DATA_W-1:0] inOp1;
  logic [DATA_W-1:0] inOp2;
  logic [DATA_W-1:0] fwdData;

  logic              holdID;
  logic              exValid;
  logic [2:0]        exWreg;
  logic              exEnFile;
  logic              exUseAlu;
  logic [DATA_W-1:0] exOp1;
  logic [DATA_W-1:0] exOp2;
  logic [CNT_W-1:0]  stallCnt;
  logic              stallErr;

  // The decode/hazard side drives the instruction and decisions.
  modport master (
    output doStall, doFwd, flush, inValid, inWreg, inEnFile, inUseAlu,
           inOp1, inOp2, fwdData,
    input  holdID, exValid, exWreg, exEnFile, exUseAlu, exOp1, exOp2,
           stallCnt, stallErr
  );

  modport slave (
    input  doStall, doFwd, flush, inValid, inWreg, inEnFile, inUseAlu,
           inOp1, inOp2, fwdData,
    output holdID, exValid, exWreg, exEnFile, exUseAlu, exOp1, exOp2,
           stallCnt, stallErr
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: bubble insertion on stall/flush, operand-1 forwarding,
// and a consecutive-stall watchdog with a sticky error flag.
module id_ex_stage #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 4,
  parameter int MAX_STALL = 2
) (
  input logic           clk,
  input logic           rstn,
  id_ex_stage_if.slave  bus
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } stage_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W:0]   STALL_LIMIT = (CNT_W + 1)'(MAX_STALL);

  stage_state_t      state;
  stage_state_t      nextState;

  logic              nValid;
  logic [2:0]        nWreg;
  logic              nEnFile;
  logic              nUseAlu;
  logic [DATA_W-1:0] nOp1;
  logic [DATA_W-1:0] nOp2;
  logic [CNT_W-1:0]  nCnt;
  logic              nErr;

  logic [CNT_W-1:0]  cntBase;
  logic [CNT_W:0]    cntInc;

  assign bus.holdID = bus.doStall & ~bus.flush;

  // Only a run of back-to-back stalls accumulates; any other edge restarts it.
  assign cntBase = (state == STALL) ? bus.stallCnt : '0;
  assign cntInc  = {1'b0, cntBase} + (CNT_W + 1)'(1);

  always_comb begin
    nextState = RUN;
    nValid    = 1'b0;
    nWreg     = '0;
    nEnFile   = 1'b0;
    nUseAlu   = 1'b0;
    nOp1      = '0;
    nOp2      = '0;
    nCnt      = '0;
    nErr      = bus.stallErr;

    if (bus.flush) begin
      nextState = RUN;
    end else if (bus.doStall) begin
      // A fully zeroed bubble keeps the hazard unit from seeing a phantom writer in EX.
      nextState = STALL;
      nCnt      = (cntBase == CNT_MAX) ? CNT_MAX : cntInc[CNT_W-1:0];
      if (cntInc > STALL_LIMIT) begin
        nErr = 1'b1;
      end
    end else begin
      nextState = RUN;
      nValid    = bus.inValid;
      nWreg     = bus.inValid ? bus.inWreg : 3'd0;
      nEnFile   = bus.inValid & bus.inEnFile;
      nUseAlu   = bus.inValid & bus.inUseAlu;
      nOp1      = bus.doFwd ? bus.fwdData : bus.inOp1;
      nOp2      = bus.inOp2;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= RUN;
      bus.exValid  <= 1'b0;
      bus.exWreg   <= '0;
      bus.exEnFile <= 1'b0;
      bus.exUseAlu <= 1'b0;
      bus.exOp1    <= '0;
      bus.exOp2    <= '0;
      bus.stallCnt <= '0;
      bus.stallErr <= 1'b0;
    end else begin
      state        <= nextState;
      bus.exValid  <= nValid;
      bus.exWreg   <= nWreg;
      bus.exEnFile <= nEnFile;
      bus.exUseAlu <= nUseAlu;
      bus.exOp1    <= nOp1;
      bus.exOp2    <= nOp2;
      bus.stallCnt <= nCnt;
      bus.stallErr <= nErr;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a table of single-edge vectors plus
// hand-written stall, watchdog, saturation and reset sequences.
module tb_id_ex_stage;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  id_ex_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_STALL(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        doStall;
    logic        doFwd;
    logic        flush;
    logic        inValid;
    logic [2:0]  inWreg;
    logic        inEnFile;
    logic        inUseAlu;
    logic [15:0] inOp1;
    logic [15:0] inOp2;
    logic [15:0] fwdData;
    logic        expHold;
    logic        expValid;
    logic [2:0]  expWreg;
    logic        expEnFile;
    logic        expUseAlu;
    logic [15:0] expOp1;
    logic [15:0] expOp2;
    logic [3:0]  expCnt;
    logic        expErr;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic fwd, input logic fl,
                               input logic valid, input logic [2:0] wreg,
                               input logic en, input logic alu,
                               input logic [15:0] op1, input logic [15:0] op2,
                               input logic [15:0] fdat);
    bus.doStall  = stall;
    bus.doFwd    = fwd;
    bus.flush    = fl;
    bus.inValid  = valid;
    bus.inWreg   = wreg;
    bus.inEnFile = en;
    bus.inUseAlu = alu;
    bus.inOp1    = op1;
    bus.inOp2    = op2;
    bus.fwdData  = fdat;
  endtask

  task automatic checkRegs(input string tag, input logic valid, input logic [2:0] wreg,
                           input logic en, input logic alu, input logic [15:0] op1,
                           input logic [15:0] op2, input logic [3:0] cnt, input logic err);
    checkOutput({tag, ".exValid"},  32'(bus.exValid),  32'(valid));
    checkOutput({tag, ".exWreg"},   32'(bus.exWreg),   32'(wreg));
    checkOutput({tag, ".exEnFile"}, 32'(bus.exEnFile), 32'(en));
    checkOutput({tag, ".exUseAlu"}, 32'(bus.exUseAlu), 32'(alu));
    checkOutput({tag, ".exOp1"},    32'(bus.exOp1),    32'(op1));
    checkOutput({tag, ".exOp2"},    32'(bus.exOp2),    32'(op2));
    checkOutput({tag, ".stallCnt"}, 32'(bus.stallCnt), 32'(cnt));
    checkOutput({tag, ".stallErr"}, 32'(bus.stallErr), 32'(err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    #7;
    rstn = 1'b1;
    #1;
  endtask

  initial begin
    logic s, f;
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 0, 16'h0, 16'h0, 16'h0);

    // Reset with random inputs across several clock edges
    for (int i = 0; i < 4; i++) begin
      s = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 1));
      applyStimulus(s, 1'($urandom_range(0, 1)), f, 1'b1, 3'($urandom_range(0, 7)),
                    1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
      tick();
      checkRegs("reset", 0, 3'd0, 0, 0, 16'h0, 16'h0, 4'd0, 0);
      checkOutput("reset.holdID", 32'(bus.holdID), 32'(s & ~f));
    end
    applyStimulus(0, 0, 0, 0, 3'd0, 0, 0, 16'h0, 16'h0, 16'h0);
    #3;
    rstn = 1'b1;
    tick();

    vecs[0] = '{"advance", 0,0,0, 1,3'd5,1,1, 16'h1234,16'hABCD,16'h0000,
                0, 1,3'd5,1,1, 16'h1234,16'hABCD, 4'd0, 0};
    vecs[1] = '{"forward", 0,1,0, 1,3'd5,1,1, 16'h1234,16'hABCD,16'h0F0F,
                0, 1,3'd5,1,1, 16'h0F0F,16'hABCD, 4'd0, 0};
    vecs[2] = '{"invalidGate", 0,0,0, 0,3'd7,1,1, 16'h1111,16'h2222,16'h0000,
                0, 0,3'd0,0,0, 16'h1111,16'h2222, 4'd0, 0};
    vecs[3] = '{"flushPrio", 1,1,1, 1,3'd4,1,1, 16'h3333,16'h4444,16'h5555,
                0, 0,3'd0,0,0, 16'h0000,16'h0000, 4'd0, 0};
    vecs[4] = '{"stallOne", 1,0,0, 1,3'd2,1,1, 16'h6666,16'h7777,16'h0000,
                1, 0,3'd0,0,0, 16'h0000,16'h0000, 4'd1, 0};
    vecs[5] = '{"advFwd", 0,1,0, 1,3'd3,0,1, 16'hFFFF,16'h0000,16'h8001,
                0, 1,3'd3,0,1, 16'h8001,16'h0000, 4'd0, 0};
    vecs[6] = '{"flushOnly", 0,0,1, 1,3'd6,1,0, 16'h1357,16'h2468,16'h0000,
                0, 0,3'd0,0,0, 16'h0000,16'h0000, 4'd0, 0};
    vecs[7] = '{"stallFwd", 1,1,0, 1,3'd1,1,1, 16'hAAAA,16'hBBBB,16'hCCCC,
                1, 0,3'd0,0,0, 16'h0000,16'h0000, 4'd1, 0};
    vecs[8] = '{"stallTwo", 1,0,0, 1,3'd1,1,1, 16'hAAAA,16'hBBBB,16'hCCCC,
                1, 0,3'd0,0,0, 16'h0000,16'h0000, 4'd2, 0};
    vecs[9] = '{"release", 0,0,0, 1,3'd1,1,1, 16'hAAAA,16'hBBBB,16'hCCCC,
                0, 1,3'd1,1,1, 16'hAAAA,16'hBBBB, 4'd0, 0};

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].doStall, vecs[i].doFwd, vecs[i].flush, vecs[i].inValid,
                    vecs[i].inWreg, vecs[i].inEnFile, vecs[i].inUseAlu,
                    vecs[i].inOp1, vecs[i].inOp2, vecs[i].fwdData);
      #1;
      checkOutput({vecs[i].name, ".holdID"}, 32'(bus.holdID), 32'(vecs[i].expHold));
      tick();
      checkRegs(vecs[i].name, vecs[i].expValid, vecs[i].expWreg, vecs[i].expEnFile,
                vecs[i].expUseAlu, vecs[i].expOp1, vecs[i].expOp2,
                vecs[i].expCnt, vecs[i].expErr);
    end

    // Watchdog: third consecutive stall trips the sticky flag
    applyStimulus(1, 0, 0, 1, 3'd6, 1, 0, 16'h5555, 16'hAAAA, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      #1;
      checkOutput("wd.holdID", 32'(bus.holdID), 32'd1);
      tick();
      checkRegs("wd.stall", 0, 3'd0, 0, 0, 16'h0, 16'h0, 4'(k), (k >= 3) ? 1'b1 : 1'b0);
    end
    applyStimulus(0, 0, 0, 1, 3'd6, 1, 0, 16'h5555, 16'hAAAA, 16'h0000);
    tick();
    checkRegs("wd.advance", 1, 3'd6, 1, 0, 16'h5555, 16'hAAAA, 4'd0, 1);
    applyStimulus(0, 0, 1, 1, 3'd6, 1, 0, 16'h5555, 16'hAAAA, 16'h0000);
    tick();
    checkRegs("wd.flush", 0, 3'd0, 0, 0, 16'h0, 16'h0, 4'd0, 1);

    // Long stall: counter saturates at 15 and never wraps
    applyStimulus(1, 0, 0, 1, 3'd2, 0, 1, 16'h0101, 16'h0202, 16'h0000);
    for (int k = 1; k <= 18; k++) begin
      tick();
      checkOutput("sat.stallCnt", 32'(bus.stallCnt), (k > 15) ? 32'd15 : 32'(k));
    end
    checkOutput("sat.stallErr", 32'(bus.stallErr), 32'd1);

    // Reset mid-stall clears outputs immediately, then the next edge resolves normally
    #2;
    rstn = 1'b0;
    #1;
    checkRegs("midReset", 0, 3'd0, 0, 0, 16'h0, 16'h0, 4'd0, 0);
    checkOutput("midReset.holdID", 32'(bus.holdID), 32'd1);
    #2;
    rstn = 1'b1;
    applyStimulus(0, 0, 0, 1, 3'd7, 1, 1, 16'hBEEF, 16'hCAFE, 16'h0000);
    tick();
    checkRegs("postReset", 1, 3'd7, 1, 1, 16'hBEEF, 16'hCAFE, 4'd0, 0);
    applyStimulus(1, 0, 0, 1, 3'd7, 1, 1, 16'hBEEF, 16'hCAFE, 16'h0000);
    tick();
    checkRegs("postReset.stall", 0, 3'd0, 0, 0, 16'h0, 16'h0, 4'd1, 0);

    doReset();
    checkRegs("finalReset", 0, 3'd0, 0, 0, 16'h0, 16'h0, 4'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that consumes the hazard unit's doStall/doFwd decisions.
- Injects bubbles into EX on a stall or flush and tells fetch/decode to hold.
- Selects the forwarded ALU result for operand 1.
- Tracks consecutive stall cycles against a watchdog limit; a stuck hazard is flagged as a sticky error.

Parameters:
- DATA_W, 16, operand data width.
- CNT_W, 4, width of the consecutive-stall counter (saturating).
- MAX_STALL, 2, stall cycles allowed in a row before stallErr sets; must be < 2^CNT_W - 1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- doStall  in  1  hazard unit: hold decode and insert bubble.
- doFwd  in  1  hazard unit: take operand 1 from fwdData.
- flush  in  1  control-flow redirect: kill the instruction in decode.
- inValid  in  1  decode holds a real instruction.
- inWreg  in  3  destination register of the decode instruction.
- inEnFile  in  1  decode instruction writes the register file.
- inUseAlu  in  1  decode instruction's result comes from the ALU.
- inOp1  in  DATA_W  register-file operand 1.
- inOp2  in  DATA_W  register-file operand 2.
- fwdData  in  DATA_W  ALU result currently in EX.
- holdID  out  1  combinational: freeze PC and IF/ID register this cycle.
- exValid  out  1  EX holds a real instruction.
- exWreg  out  3  feeds hazard unit wregEX.
- exEnFile  out  1  feeds hazard unit enFileEX.
- exUseAlu  out  1  feeds hazard unit useAluEX.
- exOp1  out  DATA_W  EX operand 1.
- exOp2  out  DATA_W  EX operand 2.
- stallCnt  out  CNT_W  consecutive stall cycles, saturating.
- stallErr  out  1  sticky watchdog flag.

Behaviour:
- Reset (rstn=0, async):
  - Every registered output is 0 and the state is RUN.
  - holdID still follows its combinational equation.
- holdID = doStall & ~flush. It has no registered delay.
- Latency is 1 cycle: decode fields at edge N appear on ex* after edge N.
- Per rising edge, priority is flush > doStall > advance.
  - flush=1 loads a bubble, state goes to RUN, stallCnt goes to 0, and doStall is ignored.
  - doStall=1 (no flush) loads a bubble and state goes to STALL.
  - Otherwise, advance:
    - exValid <= inValid.
    - exWreg/exEnFile/exUseAlu <= inputs, each gated by inValid; with inValid=0 all three load 0.
    - exOp2 <= inOp2.
    - exOp1 <= doFwd ? fwdData : inOp1.
    - State goes to RUN.
- A bubble sets exValid=0, exEnFile=0, exUseAlu=0, exWreg=0, exOp1=0 and exOp2=0. This guarantees the bubble never creates a false EX hazard.
- doFwd together with doStall or flush: the bubble wins and fwdData is not captured.
- States:
  - RUN: last edge advanced or flushed.
  - STALL: last edge stalled.
- stallCnt:
  - On each stall edge, stallCnt <= stallCnt+1, saturating at 2^CNT_W-1 (no wrap).
  - On an advance or flush edge, stallCnt <= 0.
- stallErr:
  - Sets on the edge where stallCnt+1 would exceed MAX_STALL.
  - Once set it stays at 1 until rstn; flush does not clear it.
  - It sets only on a stall edge.
- Reset mid-stall: all outputs clear immediately. On the first edge after release, stall/advance resolves normally from the current inputs.
- Widths: the operand path is pure register/mux with no arithmetic on data. The counter is unsigned.

Test Plan:
- Reset: hold rstn=0 with random inputs -> all ex*, stallCnt and stallErr read 0. holdID=doStall&~flush.
- Advance: inValid=1, inWreg=5, inEnFile=1, inUseAlu=1, inOp1=0x1234, inOp2=0xABCD, doFwd=0 -> the next cycle shows exWreg=5, exEnFile=1, exOp1=0x1234, exOp2=0xABCD.
- Forward: same stimulus with doFwd=1 and fwdData=0x0F0F -> exOp1=0x0F0F, exOp2=0xABCD.
- Stall: doStall=1 for 2 cycles, then 0:
  - holdID=1 during those cycles.
  - exValid=0 and exEnFile=0 after each stall edge.
  - stallCnt goes 1, 2, then 0 on release.
  - stallErr stays 0.
  - The held instruction enters EX on the release edge.
- Watchdog: doStall=1 for 3 cycles (MAX_STALL=2) -> stallErr=1 after the 3rd edge. It remains 1 after advance and flush, and clears only on rstn.
- Priority: flush=1 with doStall=1 and doFwd=1 -> holdID=0, a bubble is loaded, stallCnt=0 and state is RUN. inValid=0 with inEnFile=1 -> exEnFile=0.
